// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module : div_unit_pkg
// Brief  : Shared encodings and constants for the HI/LO divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

  localparam int         c_reg_width  = 32;
  localparam logic [1:0] c_div_free   = 2'b00;
  localparam logic [1:0] c_div_by_zero = 2'b01;
  localparam logic [1:0] c_div_on     = 2'b10;
  localparam logic [1:0] c_div_end    = 2'b11;
  localparam logic       c_div_start  = 1'b1;
  localparam logic       c_div_stop   = 1'b0;
  localparam logic       c_rst_enable = 1'b0;

endpackage : div_unit_pkg

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module : div_unit
// Brief  : Multi-cycle restoring divider for DIV/DIVU; remainder -> HI,
//          quotient -> LO, one-cycle write strobe on completion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = c_reg_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_div_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             we_o,
  output logic             busy_o
);

  localparam int              CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q,    state_d;
  logic [CW-1:0]    count_q,    count_d;
  logic [WIDTH-1:0] rem_q,      rem_d;
  logic [WIDTH-1:0] quot_q,     quot_d;
  logic [WIDTH-1:0] divisor_q,  divisor_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q,  neg_rem_d;
  logic [WIDTH-1:0] hi_q,       hi_d;
  logic [WIDTH-1:0] lo_q,       lo_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quot;

  always_ff @(posedge clk) begin
    if (rst == c_rst_enable) begin
      state_q    <= c_div_free;
      count_q    <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the difference only when it does not borrow.
  always_comb begin
    shifted   = {rem_q, quot_q[WIDTH-1]};
    diff      = shifted - {1'b0, divisor_q};
    step_rem  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    step_quot = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      c_div_free: begin
        if (start_i == c_div_start && !annul_i) begin
          neg_quot_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d  = signed_div_i & opdata1_i[WIDTH-1];
          quot_d     = (signed_div_i && opdata1_i[WIDTH-1]) ? ~opdata1_i + 1'b1 : opdata1_i;
          divisor_d  = (signed_div_i && opdata2_i[WIDTH-1]) ? ~opdata2_i + 1'b1 : opdata2_i;
          rem_d      = '0;
          count_d    = '0;
          state_d    = (opdata2_i == '0) ? c_div_by_zero : c_div_on;
        end
      end
      c_div_by_zero: begin
        if (annul_i) begin
          state_d = c_div_free;
        end else begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = c_div_end;
        end
      end
      c_div_on: begin
        if (annul_i) begin
          state_d = c_div_free;
        end else begin
          rem_d   = step_rem;
          quot_d  = step_quot;
          count_d = count_q + 1'b1;
          if (count_q == C_LAST) begin
            hi_d    = neg_rem_q  ? ~step_rem  + 1'b1 : step_rem;
            lo_d    = neg_quot_q ? ~step_quot + 1'b1 : step_quot;
            state_d = c_div_end;
          end
        end
      end
      default: state_d = c_div_free;
    endcase
  end

  always_comb begin
    busy_o = (state_q == c_div_by_zero) || (state_q == c_div_on);
    we_o   = (state_q == c_div_end);
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

endmodule : div_unit

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module : tb_div_unit
// Brief  : Self-checking bench for div_unit against an integer-division model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         signed_div_i;
  logic         annul_i;
  logic [W-1:0] opdata1_i;
  logic [W-1:0] opdata2_i;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         we_o;
  logic         busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .we_o         (we_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit integer division truncating toward zero; x/0 gives 0,0.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return 64'd0;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge, unit idle.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [63:0] exp;
    int          lat;
    int          exp_lat;
    bit          busy_ok;
    exp     = ref_div(sgn, a, b);
    exp_lat = (b == '0) ? 2 : W + 1;
    busy_ok = 1'b1;
    lat     = 0;
    start_i = 1'b1; signed_div_i = sgn; opdata1_i = a; opdata2_i = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      if (we_o) begin
        lat = k;
        break;
      end
      if (!busy_o) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_while_running"}, 64'(busy_ok), 64'd1);
    check({tag, " hi_lo"}, {hi_o, lo_o}, exp);
    check({tag, " busy_at_we"}, 64'(busy_o), 64'd0);
    @(negedge clk);
    check({tag, " we_single"}, 64'(we_o), 64'd0);
    check({tag, " hi_lo_held"}, {hi_o, lo_o}, exp);
  endtask

  initial begin
    logic [63:0] prev;
    logic [W-1:0] a, b;
    int pulses;

    rst = 1'b0; start_i = 1'b0; signed_div_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {hi_o, lo_o, 30'd0, we_o, busy_o}, 96'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset idle", {30'd0, we_o, busy_o}, 32'd0);

    run_op("divu 100/7", 1'b0, 32'd100, 32'd7);
    check("divu 100/7 literal", {hi_o, lo_o}, {32'd2, 32'd14});
    run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div -7/2 literal", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    check("div 7/-2 literal", {hi_o, lo_o}, {32'd1, 32'hFFFF_FFFD});
    run_op("divu 5/0", 1'b0, 32'd5, 32'd0);
    run_op("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div overflow literal", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
    run_op("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1);

    // Annul mid-operation: no strobe, results untouched, next op accepted at once.
    prev = {hi_o, lo_o};
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
    end
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul idle", {30'd0, we_o, busy_o}, 32'd0);
    check("annul hi_lo kept", {hi_o, lo_o}, prev);
    run_op("divu 9/3 after annul", 1'b0, 32'd9, 32'd3);

    // Start together with annul while idle is rejected.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("start+annul rejected", {31'd0, busy_o}, 32'd0);

    // Reset in the middle of an operation.
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd11;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    check("mid-op reset", {hi_o, lo_o, 30'd0, we_o, busy_o}, 96'd0);
    rst = 1'b1;
    @(negedge clk);

    // start_i held through completion yields exactly one strobe.
    pulses = 0;
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (we_o) pulses++;
    end
    start_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (we_o) pulses++;
    end
    check("held start pulses", 64'(pulses), 64'd1);
    check("held start result", {hi_o, lo_o}, {32'd2, 32'd14});

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 16));
        1:       b = (i % 2 == 0) ? 32'd0 : ~32'($urandom_range(0, 15));
        2:       b = $urandom;
        default: b = a >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_unit

`default_nettype wire
